// File: rtl/uart_rx_msg_detect.sv
// uart_rx_msg_detect: watches the uart_rx byte/strobe stream for the reply
// "OK" (optionally followed by CR or LF). Each match produces a one-cycle
// ok_pulse, bumps a saturating match counter and sets a sticky LED. Broken
// or stalled messages produce a one-cycle err_pulse.
//
// Handshake: recv_valid is a one-cycle strobe; byte_recv is only looked at
// on cycles where recv_valid=1. There is no backpressure, so every strobed
// byte is consumed on the edge it is presented, including back-to-back strobes.
module uart_rx_msg_detect #(
  parameter int CLKS_PER_BIT  = 217,
  parameter int TIMEOUT_BYTES = 4,
  parameter int REQUIRE_TERM  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_recv,
  input  logic       recv_valid,
  output logic       ok_pulse,
  output logic       err_pulse,
  output logic [7:0] ok_count,
  output logic       led_ok,
  output logic [2:0] state_dbg
);

  // Ten bit times per byte (start + 8 data + stop).
  localparam int TIMEOUT_CLKS = CLKS_PER_BIT * 10 * TIMEOUT_BYTES;
  localparam int TW           = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CLKS);
  localparam bit NEED_TERM = (REQUIRE_TERM != 0);

  localparam logic [7:0] CH_O  = 8'h4F;
  localparam logic [7:0] CH_K  = 8'h4B;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    RX_O = 3'b010,
    RX_K = 3'b100
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          match;

  // A match is decided by the byte that completes the message.
  always_comb begin
    match = 1'b0;
    if (recv_valid) begin
      if (state == RX_O && byte_recv == CH_K && !NEED_TERM)
        match = 1'b1;
      else if (state == RX_K && (byte_recv == CH_CR || byte_recv == CH_LF))
        match = 1'b1;
    end
  end

  // Message FSM, inter-byte timer and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      ok_pulse  <= 1'b0;
      err_pulse <= 1'b0;
      ok_count  <= 8'd0;
      led_ok    <= 1'b0;
    end else begin
      ok_pulse  <= 1'b0;
      err_pulse <= 1'b0;

      // Timer measures the gap since the last byte of a partial message;
      // it saturates instead of wrapping.
      if (recv_valid || state == IDLE)
        timer <= '0;
      else if (timer != TIMER_MAX)
        timer <= timer + 1'b1;

      if (match) begin
        ok_pulse <= 1'b1;
        led_ok   <= 1'b1;
        if (ok_count != 8'hFF)
          ok_count <= ok_count + 8'd1;
      end

      if (recv_valid) begin
        case (state)
          IDLE: begin
            if (byte_recv == CH_O) state <= RX_O;
          end
          RX_O: begin
            if (byte_recv == CH_K) begin
              state <= NEED_TERM ? RX_K : IDLE;
            end else if (byte_recv == CH_O) begin
              // Repeated 'O' just restarts the message silently.
              state <= RX_O;
            end else begin
              state     <= IDLE;
              err_pulse <= 1'b1;
            end
          end
          RX_K: begin
            if (byte_recv == CH_CR || byte_recv == CH_LF) begin
              state <= IDLE;
            end else if (byte_recv == CH_O) begin
              // Broken message, but this 'O' may begin a new one.
              state     <= RX_O;
              err_pulse <= 1'b1;
            end else begin
              state     <= IDLE;
              err_pulse <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && timer == TIMER_LAST) begin
        state     <= IDLE;
        err_pulse <= 1'b1;
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx_msg_detect.sv
// Testbench for uart_rx_msg_detect: directed scenarios followed by random
// byte streams, checked against a message-level model and a pulse scoreboard.
module tb_uart_rx_msg_detect;

  localparam int CPB = 4;
  localparam int TO_BYTES = 4;
  localparam int REQ = 1;
  localparam int T = CPB * 10 * TO_BYTES;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] byte_recv = 8'h00;
  logic       recv_valid = 1'b0;
  logic       ok_pulse;
  logic       err_pulse;
  logic [7:0] ok_count;
  logic       led_ok;
  logic [2:0] state_dbg;

  uart_rx_msg_detect #(
    .CLKS_PER_BIT (CPB),
    .TIMEOUT_BYTES(TO_BYTES),
    .REQUIRE_TERM (REQ)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_recv (byte_recv),
    .recv_valid(recv_valid),
    .ok_pulse  (ok_pulse),
    .err_pulse (err_pulse),
    .ok_count  (ok_count),
    .led_ok    (led_ok),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Expected pulse events: {edge number[31:0], ok, err, ok_count[7:0], led}
  logic [42:0] exp_q[$];

  // ---------------- reference model ----------------
  // m_len = how many leading bytes of the expected message have been seen.
  int         m_len = 0;
  int         m_idle = 0;
  logic [7:0] m_cnt = 8'd0;
  bit         m_led = 1'b0;
  bit         have_exp = 1'b0;

  function automatic bit byte_fits(input int pos, input logic [7:0] b);
    case (pos)
      0: return b == 8'h4F;
      1: return b == 8'h4B;
      2: return (REQ != 0) && (b == 8'h0D || b == 8'h0A);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] exp_state(input int len);
    case (len)
      1: return 3'b010;
      2: return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

  task automatic push_event(input bit ok, input bit err);
    logic [31:0] when;
    when = 32'(cyc + 1);
    exp_q.push_back({when, ok, err, m_cnt, m_led});
  endtask

  task automatic model_byte(input logic [7:0] b);
    int full;
    bit err;
    full = (REQ != 0) ? 3 : 2;
    if (byte_fits(m_len, b)) begin
      m_len++;
      if (m_len == full) begin
        m_len = 0;
        if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
        m_led = 1'b1;
        push_event(1'b1, 1'b0);
      end
    end else begin
      err = (m_len > 0) && !(m_len == 1 && b == 8'h4F);
      m_len = (b == 8'h4F) ? 1 : 0;
      if (err) push_event(1'b0, 1'b1);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit v, input logic [7:0] b, input bit r);
    @(negedge clk);
    if (have_exp) begin
      checks++;
      if ({state_dbg, ok_count, led_ok} !== {exp_state(m_len), m_cnt, m_led}) begin
        errors++;
        $display("FAIL status cyc=%0d got state=%b cnt=%0d led=%b exp state=%b cnt=%0d led=%b",
                 cyc, state_dbg, ok_count, led_ok, exp_state(m_len), m_cnt, m_led);
      end
    end
    rst_n      = r;
    recv_valid = v;
    byte_recv  = b;
    have_exp   = 1'b1;
    if (!r) begin
      m_len = 0; m_idle = 0; m_cnt = 8'd0; m_led = 1'b0;
    end else if (v) begin
      m_idle = 0;
      model_byte(b);
    end else if (m_len > 0) begin
      m_idle++;
      if (m_idle == T) begin
        m_len = 0;
        m_idle = 0;
        push_event(1'b0, 1'b1);
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_msg(input logic [7:0] term);
    send(8'h4F); send(8'h4B); send(term);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [42:0] e;
    while (exp_q.size() > 0 && exp_q[0][42:11] < 32'(cyc)) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_pulse cyc=%0d got none exp ok=%b err=%b at cyc=%0d",
               cyc, e[10], e[9], e[42:11]);
    end
    if (ok_pulse === 1'b1 || err_pulse === 1'b1) begin
      checks++;
      if (exp_q.size() == 0 || exp_q[0][42:11] != 32'(cyc)) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d got ok=%b err=%b exp no pulse",
                 cyc, ok_pulse, err_pulse);
      end else begin
        e = exp_q.pop_front();
        if ({ok_pulse, err_pulse, ok_count, led_ok} !== e[10:0]) begin
          errors++;
          $display("FAIL pulse cyc=%0d got ok=%b err=%b cnt=%0d led=%b exp ok=%b err=%b cnt=%0d led=%b",
                   cyc, ok_pulse, err_pulse, ok_count, led_ok, e[10], e[9], e[8:1], e[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [7:0] pick_byte();
    case ($urandom_range(0, 9))
      0, 1, 2: return 8'h4F;
      3, 4:    return 8'h4B;
      5:       return 8'h0D;
      6:       return 8'h0A;
      7:       return 8'h6F;
      8:       return 8'h6B;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    do_reset();

    // 1: basic match with CR
    send_msg(8'h0D);
    idle(3);

    // 2: mismatch after 'O', then match with LF
    do_reset();
    send(8'h4F); send(8'h41);
    idle(2);
    send_msg(8'h0A);
    idle(2);

    // 3: repeated 'O' restarts silently
    do_reset();
    send(8'h4F); send(8'h4F); send(8'h4B); send(8'h0D);
    idle(2);

    // RX_K error paths: 'O' restarts with error, other byte drops to idle
    send(8'h4F); send(8'h4B); send(8'h4F); send(8'h4B); send(8'h0A);
    send(8'h4F); send(8'h4B); send(8'h4B);
    send(8'h6F); send(8'h6B);
    idle(2);

    // 4: timeout exactly at expiry, then a byte on the expiry cycle
    do_reset();
    send(8'h4F);
    idle(T);
    idle(3);
    send(8'h4F);
    idle(T - 1);
    send(8'h4B);
    idle(T - 1);
    send(8'h0D);
    idle(3);

    // 5: saturation of the match counter
    do_reset();
    for (int i = 0; i < 256; i++) send_msg((i % 2) ? 8'h0A : 8'h0D);
    idle(2);
    send_msg(8'h0D);
    idle(2);

    // 6: reset in RX_K with three matches, then a stray terminator
    do_reset();
    for (int i = 0; i < 3; i++) send_msg(8'h0D);
    send(8'h4F); send(8'h4B);
    step(1'b0, 8'h00, 1'b0);
    send(8'h0D);
    idle(2);

    // Random streams with occasional long gaps and resets
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 99))
        0:       step(1'b0, 8'h00, 1'b0);
        1, 2:    idle($urandom_range(T - 3, T + 2));
        default: begin
          if ($urandom_range(0, 2) != 0) send(pick_byte());
          else idle(1);
        end
      endcase
    end

    idle(T + 4);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending events exp 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
